uart_baud_gen_prog: RTL

Runtime-programmable UART baud/oversample tick generator, successor to the fixed-divisor generator. It adds:
- a software-loaded divisor with a valid/ready handshake;
- a parametrised oversample rate;
- a mid-bit tick for the RX sampler;
- an RX resync input that realigns bit phase on a start-bit edge.

It sits between the UART CSR block (divisor source) and the uart TX/RX engines (tick consumers).

---
 rtl/uart_baud_gen_prog_pkg.sv | 29 ++
 rtl/uart_baud_gen_prog_frac_div.sv | 60 ++++++
 rtl/uart_baud_gen_prog.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_prog_pkg.sv
// Shared UART baud-generator constants, config struct, handshake states and default-divisor helper.
// The fractional divider is enabled by defining UART_BAUD_FRAC_EN.
package uart_baud_gen_prog_pkg;

  // System clock and baud rate; CLK_FREQ mirrors the value kept in riscv_defines
  localparam int unsigned CLK_FREQ    = 50_000_000;
  localparam int unsigned BAUD_RATE   = 115_200;

  localparam int unsigned UART_DIV_W  = 16;
  localparam int unsigned UART_FRAC_W = 4;
  localparam int unsigned UART_OSR    = 16;

  typedef struct packed {
    logic [UART_DIV_W-1:0]  div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } uart_div_cfg_t;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

  function automatic int unsigned uart_default_div(input int unsigned clk_freq,
                                                   input int unsigned baud_rate,
                                                   input int unsigned osr);
    return clk_freq / (baud_rate * osr);
  endfunction

endpackage

// File: rtl/uart_baud_gen_prog_frac_div.sv
// Sample-period counter with optional fractional accumulator (UART_BAUD_FRAC_EN); emits a
// combinational wrap pulse in the last cycle of each sample period.
module uart_frac_div #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clear,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              wrap
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] period_m1;
  logic             carry;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;

  // The carry of the pending addition stretches the current period by one cycle
  assign acc_sum = {1'b0, acc} + {1'b0, div_frac};
  assign carry   = acc_sum[FRAC_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (!en || clear) begin
      acc <= '0;
    end else if (wrap) begin
      acc <= acc_sum[FRAC_W-1:0];
    end
  end
`else
  logic unused_frac;

  assign unused_frac = ^div_frac;
  assign carry       = 1'b0;
`endif

  // Divisors of 0 and 1 both mean a tick every enabled cycle
  assign div_eff   = (div_int > DIV_W'(1)) ? div_int : DIV_W'(1);
  assign period_m1 = div_eff - DIV_W'(1) + DIV_W'(carry);
  assign wrap      = en && (cnt == period_m1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!en || clear || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen_prog.sv
// Programmable UART oversample/mid-bit/baud tick generator with divisor handshake and RX resync.
// Fractional division is compiled in only when UART_BAUD_FRAC_EN is defined.
//
// state    | meaning
// CFG_IDLE | no divisor pending, cfg_ready high
// CFG_PEND | divisor latched, waiting for baud wrap (or en low) to apply
module uart_baud_gen_prog
  import uart_baud_gen_prog_pkg::*;
#(
  parameter int unsigned DIV_W       = UART_DIV_W,
  parameter int unsigned FRAC_W      = UART_FRAC_W,
  parameter int unsigned OSR         = UART_OSR,
  parameter int unsigned DEFAULT_DIV = uart_default_div(CLK_FREQ, BAUD_RATE, OSR)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic              resync,
  output logic              sample_tick,
  output logic              mid_tick,
  output logic              baud_tick
);

  localparam int unsigned       BAUD_W  = $clog2(OSR);
  localparam logic [BAUD_W-1:0] MID_IDX = BAUD_W'(OSR / 2 - 1);
  localparam logic [BAUD_W-1:0] END_IDX = BAUD_W'(OSR - 1);

  typedef struct packed {
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
  } div_cfg_t;

  cfg_state_t        state;
  cfg_state_t        state_nxt;
  div_cfg_t          active_cfg;
  div_cfg_t          pend_cfg;
  logic              load_pend;
  logic              apply;
  logic              wrap;
  logic              baud_wrap;
  logic              resync_act;
  logic              div_clear;
  logic [BAUD_W-1:0] baud_cnt;

  assign resync_act = resync && en;
  assign baud_wrap  = wrap && (baud_cnt == END_IDX);
  assign div_clear  = resync_act || apply;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= CFG_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    load_pend = 1'b0;
    apply     = 1'b0;
    case (state)
      CFG_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          load_pend = 1'b1;
          state_nxt = CFG_PEND;
        end
      end
      CFG_PEND: begin
        // Apply only at a bit boundary so the bit in flight keeps its rate
        if (!en || baud_wrap) begin
          apply     = 1'b1;
          state_nxt = CFG_IDLE;
        end
      end
      default: state_nxt = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_cfg <= '0;
    end else if (load_pend) begin
      pend_cfg <= '{div_int: cfg_div_int, div_frac: cfg_div_frac};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_cfg <= '{div_int: DIV_W'(DEFAULT_DIV), div_frac: '0};
    end else if (apply) begin
      active_cfg <= pend_cfg;
    end
  end

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .clear    (div_clear),
    .div_int  (active_cfg.div_int),
    .div_frac (active_cfg.div_frac),
    .wrap     (wrap)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_cnt <= '0;
    end else if (!en || resync_act) begin
      baud_cnt <= '0;
    end else if (wrap) begin
      baud_cnt <= baud_cnt + BAUD_W'(1);
    end
  end

  // All three ticks come from the same wrap so they can never skew
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_tick <= 1'b0;
      mid_tick    <= 1'b0;
      baud_tick   <= 1'b0;
    end else begin
      sample_tick <= wrap && !resync_act;
      mid_tick    <= wrap && !resync_act && (baud_cnt == MID_IDX);
      baud_tick   <= baud_wrap && !resync_act;
    end
  end

endmodule
